// File: rtl/qmon_pkg.sv
// Shared definitions for the latch Q edge monitor: FSM encoding and
// default parameter values.
package qmon_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_PEND   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_PEND   = 2'd3
  } qmon_state_e;

  localparam int QMON_SYNC_STAGES = 2;
  localparam int QMON_STABLE_CYC  = 2;
  localparam int QMON_CNT_W       = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/q_edge_monitor.sv
// Synchronizes latch Q, debounces it with a minimum-stable-time rule and
// reports a clean level, edge/glitch strobes and event counters.
module q_edge_monitor
  import qmon_pkg::*;
#(
  parameter int SYNC_STAGES = QMON_SYNC_STAGES,
  parameter int STABLE_CYC  = QMON_STABLE_CYC,
  parameter int CNT_W       = QMON_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_CYC);

  logic              q_sync;
  qmon_state_e       state, state_nxt;
  logic [STAB_W-1:0] stab, stab_nxt, stab_inc;
  logic              acc_r, acc_f, rej;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (q_sync)
  );

  assign stab_inc = stab + STAB_W'(1);

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    acc_r     = 1'b0;
    acc_f     = 1'b0;
    rej       = 1'b0;
    case (state)
      LOW_STABLE:
        if (q_sync) begin
          if (STABLE_CYC == 1) begin
            state_nxt = HIGH_STABLE;
            acc_r     = 1'b1;
          end else begin
            state_nxt = RISE_PEND;
            stab_nxt  = STAB_W'(1);
          end
        end
      RISE_PEND:
        if (q_sync) begin
          if (stab_inc == STAB_TGT) begin
            state_nxt = HIGH_STABLE;
            stab_nxt  = '0;
            acc_r     = 1'b1;
          end else begin
            stab_nxt  = stab_inc;
          end
        end else begin
          state_nxt = LOW_STABLE;
          stab_nxt  = '0;
          rej       = 1'b1;
        end
      HIGH_STABLE:
        if (!q_sync) begin
          if (STABLE_CYC == 1) begin
            state_nxt = LOW_STABLE;
            acc_f     = 1'b1;
          end else begin
            state_nxt = FALL_PEND;
            stab_nxt  = STAB_W'(1);
          end
        end
      FALL_PEND:
        if (!q_sync) begin
          if (stab_inc == STAB_TGT) begin
            state_nxt = LOW_STABLE;
            stab_nxt  = '0;
            acc_f     = 1'b1;
          end else begin
            stab_nxt  = stab_inc;
          end
        end else begin
          state_nxt = HIGH_STABLE;
          stab_nxt  = '0;
          rej       = 1'b1;
        end
      default: begin
        state_nxt = LOW_STABLE;
        stab_nxt  = '0;
      end
    endcase
  end

  // Strobes are registered copies of the decisions so outputs stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOW_STABLE;
      stab   <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_nxt;
      stab   <= stab_nxt;
      rise   <= acc_r;
      fall   <= acc_f;
      glitch <= rej;
      if (acc_r)      level <= 1'b1;
      else if (acc_f) level <= 1'b0;
    end
  end

  // clr beats a coincident increment; the strobes above are unaffected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (clr) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (acc_r) rise_cnt <= rise_cnt + CNT_W'(1);
      if (acc_f) fall_cnt <= fall_cnt + CNT_W'(1);
      if (rej && (glitch_cnt != {CNT_W{1'b1}}))
        glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_q_edge_monitor.sv
// Directed bench for q_edge_monitor: default instance plus a CNT_W=2
// instance sharing the same stimulus for wrap/saturate checks.
module tb_q_edge_monitor;
  import qmon_pkg::*;

  logic       clk, rst_n, q_in, clr;
  logic       level, rise, fall, glitch;
  logic [7:0] rise_cnt, fall_cnt, glitch_cnt;
  logic       level2, rise2, fall2, glitch2;
  logic [1:0] rise_cnt2, fall_cnt2, glitch_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_seen = 0, fall_seen = 0, glitch_seen = 0, overlap = 0;

  q_edge_monitor dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .level(level), .rise(rise), .fall(fall), .glitch(glitch),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .glitch_cnt(glitch_cnt)
  );

  q_edge_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .level(level2), .rise(rise2), .fall(fall2), .glitch(glitch2),
    .rise_cnt(rise_cnt2), .fall_cnt(fall_cnt2), .glitch_cnt(glitch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    rise_seen   += int'(rise);
    fall_seen   += int'(fall);
    glitch_seen += int'(glitch);
    if (int'(rise) + int'(fall) + int'(glitch) > 1) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; q_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    rise_seen = 0; fall_seen = 0; glitch_seen = 0; overlap = 0;
  endtask

  task automatic toggle(input int n);
    repeat (n) begin
      q_in = 1'b1; tick(6);
      q_in = 1'b0; tick(6);
    end
  endtask

  task automatic pulse_glitch(input int n);
    repeat (n) begin
      q_in = 1'b1; tick(1);
      q_in = 1'b0; tick(4);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; q_in = 1'b1;
    #2;
    // reset held 3 cycles with q_in high
    tick(3);
    chk("rst_level", level, 0);
    chk("rst_strobes", {rise, fall, glitch}, 0);
    chk("rst_cnts", {rise_cnt, fall_cnt, glitch_cnt}, 0);
    rst_n = 1'b1;
    tick(3);
    chk("rise_not_early", {rise, level}, 0);
    tick(1);
    chk("rise_edge4", {rise, level}, 2'b11);
    chk("rise_cnt_1", rise_cnt, 1);
    tick(1);
    chk("rise_one_cycle", {rise, level}, 2'b01);
    // falling edge latency mirrors rising
    q_in = 1'b0;
    tick(3);
    chk("fall_not_early", {fall, level}, 2'b01);
    tick(1);
    chk("fall_edge4", {fall, level}, 2'b10);
    chk("fall_cnt_1", fall_cnt, 1);

    // clean toggles
    do_reset();
    toggle(3);
    chk("tog_rise_cnt", rise_cnt, 3);
    chk("tog_fall_cnt", fall_cnt, 3);
    chk("tog_glitch_cnt", glitch_cnt, 0);
    chk("tog_rise_pulses", rise_seen, 3);
    chk("tog_fall_pulses", fall_seen, 3);
    chk("tog_overlap", overlap, 0);
    chk("tog_level", level, 0);

    // single-cycle glitch
    do_reset();
    q_in = 1'b1; tick(1);
    q_in = 1'b0; tick(2);
    chk("gl_not_early", glitch, 0);
    tick(1);
    chk("gl_pulse", {glitch, level}, 2'b10);
    chk("gl_cnt", glitch_cnt, 1);
    tick(1);
    chk("gl_one_cycle", glitch, 0);
    chk("gl_no_edges", rise_seen + fall_seen, 0);

    // wrap and saturate
    do_reset();
    toggle(5);
    chk("wrap_rise2", rise_cnt2, 1);
    chk("wrap_fall2", fall_cnt2, 1);
    chk("nowrap_rise", rise_cnt, 5);
    pulse_glitch(5);
    chk("sat_glitch2", glitch_cnt2, 3);
    chk("glitch_cnt5", glitch_cnt, 5);
    chk("glitch_pulses", glitch_seen, 5);
    chk("sat_level", {level, level2}, 0);

    // clr colliding with an accepted rise
    do_reset();
    toggle(1);
    chk("clr_pre", {rise_cnt, fall_cnt}, 16'h0101);
    q_in = 1'b1; tick(3);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("clr_rise_pulse", {rise, level}, 2'b11);
    chk("clr_wins", {rise_cnt, fall_cnt}, 0);
    tick(1);
    chk("clr_hold", rise_cnt, 0);

    // reset while a rise is pending
    do_reset();
    toggle(1);
    q_in = 1'b1; tick(3);
    chk("mid_state_pend", dut.state, RISE_PEND);
    rise_seen = 0;
    rst_n = 1'b0; tick(1);
    chk("mid_state", dut.state, LOW_STABLE);
    chk("mid_outs", {level, rise, fall, glitch}, 0);
    chk("mid_cnts", {rise_cnt, fall_cnt, glitch_cnt}, 0);
    q_in = 1'b0;
    rst_n = 1'b1; tick(6);
    chk("mid_no_rise", rise_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/q_edge_monitor.md
# q_edge_monitor

Downstream consumer of the delayed D-latch output. Brings the latch `Q` into the `clk` domain, debounces it against a minimum-stable-time rule, and emits a clean level, one-cycle rise/fall strobes, and rise/fall/glitch counters. The latch testbenches use it to check latch output behaviour without inspecting waveforms by hand.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flop count, must be ≥ 2.
- `STABLE_CYC`, 2: consecutive cycles a new synchronized value must hold before it is accepted, must be ≥ 1.
- `CNT_W`, 8: width of each counter.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `q_in`, in, 1: latch `Q` output; asynchronous to `clk`.
- `clr`, in, 1: synchronous counter clear; does not affect the FSM.
- `level`, out, 1: debounced level of `q_in`.
- `rise`, out, 1: one-cycle strobe when `level` goes 0→1.
- `fall`, out, 1: one-cycle strobe when `level` goes 1→0.
- `glitch`, out, 1: one-cycle strobe when a pending change is rejected.
- `rise_cnt`, out, CNT_W: accepted rising edges; wraps.
- `fall_cnt`, out, CNT_W: accepted falling edges; wraps.
- `glitch_cnt`, out, CNT_W: rejected changes; saturates at all-ones.

## Operation
- The synchronizer is a shift chain of `SYNC_STAGES` flops. Its last stage is `q_sync`.
- FSM states: `LOW_STABLE`, `RISE_PEND`, `HIGH_STABLE`, `FALL_PEND`. Stability counter `stab` is sized for 0..STABLE_CYC.
- `LOW_STABLE`, `q_sync`=1:
  - If STABLE_CYC=1: go to `HIGH_STABLE` and accept.
  - Otherwise: go to `RISE_PEND` with `stab`=1.
- `RISE_PEND`, `q_sync`=1: `stab`++. When the incremented value equals STABLE_CYC, go to `HIGH_STABLE` and accept.
- `RISE_PEND`, `q_sync`=0: go to `LOW_STABLE`, reject, clear `stab`.
- `HIGH_STABLE` and `FALL_PEND` mirror the above with polarity inverted.
- Accept: `level` takes the new value, the matching strobe pulses, and the matching counter increments.
- Reject: `glitch` pulses and `glitch_cnt` increments unless it is already saturated. `level` is unchanged.
- At most one of `rise`/`fall`/`glitch` is high in any cycle.
- Counter arithmetic is modulo 2^CNT_W for rise/fall. `glitch_cnt` holds at 2^CNT_W−1.
- If `clr` coincides with an increment, clear wins and the counter is 0 after the edge. Strobes still fire.

## Timing
- Reset values: `level`, `rise`, `fall`, `glitch` = 0; all counters = 0; FSM = `LOW_STABLE`; `stab` = 0; synchronizer = 0.
- `rst_n` low mid-operation discards any pending change and raises no strobe. Reset has priority over `clr`.
- Let edge k be the first `clk` edge that samples `q_in`=1 and `q_in` stays high.
  - `q_sync` is 1 after edge k+SYNC_STAGES−1.
  - `level` rises and `rise` is high for exactly one cycle after edge k+SYNC_STAGES+STABLE_CYC−1.
  - With defaults, `rise` appears after edge k+3.
- Falling edges have the same latency.
- Glitch rule: a synchronized pulse lasting P cycles, with 1 ≤ P < STABLE_CYC, yields `glitch`=1 for one cycle after the edge that samples the revert. It yields no `rise`/`fall`.
- All outputs are registered. There is no combinational path from `q_in`, `clr` or `rst_n` to any output.

## Structure
- The shared package `qmon_pkg` holds:
  - the FSM state encoding (2-bit localparams or enum: LOW_STABLE=0, RISE_PEND=1, HIGH_STABLE=2, FALL_PEND=3);
  - the default values of `SYNC_STAGES`, `STABLE_CYC` and `CNT_W`.
- Sub-module `sync_chain` (params `STAGES`; ports `clk`, `rst_n`, `d`, `q`) is reused by other latch/flop test blocks.
- The FSM, stability counter and the three counters stay in the top module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `q_in`=1 → all outputs 0. After release, `rise` fires after edge 4 with defaults.
- Clean toggles: `q_in` high 6 cycles, low 6 cycles, repeated 3× → rise_cnt=3, fall_cnt=3, glitch_cnt=0, no overlapping strobes.
- Glitch: with defaults, a 1-cycle `q_in` pulse aligned to `clk` → one `glitch` pulse, glitch_cnt=1, `level` stays 0.
- Wrap/saturate: with CNT_W=2, 5 accepted rises → rise_cnt=1. 5 glitches → glitch_cnt=3.
- `clr` collision: assert `clr` on the cycle `rise` is produced → rise_cnt=0 after the edge, `rise` still pulses.
- Reset mid-pend: drop `rst_n` while in `RISE_PEND` → no `rise` pulse, FSM=`LOW_STABLE`, counters 0.
